// File: rtl/wave_sweep_ctrl.sv
// wave_sweep_ctrl: steps a DDS frequency word from freq_start to freq_stop,
// holding each word for a programmable dwell, with optional auto-restart.
//
// Ports:
//   clk, rst_n      clock; rst_n is a synchronous, ACTIVE-HIGH reset
//   start, stop     single-cycle sweep request / abort (stop has priority)
//   loop_en         restart the sweep automatically after completion
//   freq_start/stop first and last frequency word of the sweep
//   freq_step       step magnitude (0 is treated as 1)
//   dwell           cycles spent at each frequency (0 is treated as 1)
//   wave_sel_in     waveform select, followed while idle, latched at LOAD
//   freq_word       frequency word to the DDS
//   waveform_sel    waveform select to the DDS
//   busy            high in LOAD, DWELL, STEP and DONE
//   done            one-cycle pulse on sweep completion
//   sweep_cnt       completed-sweep counter (wraps)
//
// Build option: define SWEEP_AUTO_WAVE_EN to advance waveform_sel on every
// DONE and keep the advanced value across looped sweeps.
module wave_sweep_ctrl #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [7:0]         freq_start,
  input  logic [7:0]         freq_stop,
  input  logic [7:0]         freq_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         wave_sel_in,
  output logic [7:0]         freq_word,
  output logic [1:0]         waveform_sel,
  output logic               busy,
  output logic               done,
  output logic [7:0]         sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DWELL = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q;
  logic [7:0]           freq_q;
  logic [7:0]           stop_q;
  logic [7:0]           step_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic                 up_q;
  logic                 loop_q;
  logic [1:0]           wave_q;
  logic                 busy_q;
  logic                 done_q;
  logic [7:0]           sweep_cnt_q;
`ifdef SWEEP_AUTO_WAVE_EN
  logic                 loop_pass_q;  // current LOAD came from DONE, not start
`endif

  logic [8:0]           step_sum_d;
  logic [7:0]           freq_d;
  logic                 dwell_end_c;

  // Next frequency word, computed 9 bits wide and clamped to freq_stop.
  always_comb begin
    step_sum_d = '0;
    freq_d     = freq_q;
    if (up_q) begin
      step_sum_d = {1'b0, freq_q} + {1'b0, step_q};
      freq_d     = (step_sum_d > {1'b0, stop_q}) ? stop_q : step_sum_d[7:0];
    end else begin
      step_sum_d = {1'b0, freq_q} - {1'b0, step_q};
      freq_d     = (step_sum_d[8] || (step_sum_d[7:0] < stop_q)) ? stop_q : step_sum_d[7:0];
    end
  end

  assign dwell_end_c = (cnt_q == (dwell_q - DWELL_W'(1)));

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      freq_q      <= 8'd0;
      stop_q      <= 8'd0;
      step_q      <= 8'd0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      up_q        <= 1'b0;
      loop_q      <= 1'b0;
      wave_q      <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sweep_cnt_q <= 8'd0;
`ifdef SWEEP_AUTO_WAVE_EN
      loop_pass_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wave_q <= wave_sel_in;
`ifdef SWEEP_AUTO_WAVE_EN
          loop_pass_q <= 1'b0;
`endif
          if (start && !stop) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            stop_q  <= freq_stop;
            step_q  <= (freq_step == 8'd0) ? 8'd1 : freq_step;
            dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
            up_q    <= (freq_stop >= freq_start);
            loop_q  <= loop_en;
            freq_q  <= freq_start;
            cnt_q   <= '0;
            state_q <= S_DWELL;
`ifdef SWEEP_AUTO_WAVE_EN
            if (!loop_pass_q) wave_q <= wave_sel_in;
            loop_pass_q <= 1'b0;
`else
            wave_q <= wave_sel_in;
`endif
          end
        end
        S_DWELL: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
            if (dwell_end_c) begin
              if (freq_q != stop_q) begin
                state_q <= S_STEP;
              end else begin
                state_q     <= S_DONE;
                done_q      <= 1'b1;
                sweep_cnt_q <= sweep_cnt_q + 8'd1;
`ifdef SWEEP_AUTO_WAVE_EN
                wave_q      <= wave_q + 2'd1;
`endif
              end
            end
          end
        end
        S_STEP: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            freq_q  <= freq_d;
            cnt_q   <= '0;
            state_q <= S_DWELL;
          end
        end
        S_DONE: begin
          if (!stop && loop_q) begin
            state_q <= S_LOAD;
`ifdef SWEEP_AUTO_WAVE_EN
            loop_pass_q <= 1'b1;
`endif
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign freq_word    = freq_q;
  assign waveform_sel = wave_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sweep_cnt    = sweep_cnt_q;

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// Self-checking bench for wave_sweep_ctrl: directed sweeps plus random sweeps,
// each compared cycle by cycle against a frequency list built by plain arithmetic.
module tb_wave_sweep_ctrl;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [7:0]    freq_start;
  logic [7:0]    freq_stop;
  logic [7:0]    freq_step;
  logic [DW-1:0] dwell;
  logic [1:0]    wave_sel_in;
  logic [7:0]    freq_word;
  logic [1:0]    waveform_sel;
  logic          busy;
  logic          done;
  logic [7:0]    sweep_cnt;

  int total;
  int bad;
  int cnt_exp;   // expected completed-sweep count
  int prev_f;    // expected frequency word held while idle

  wave_sweep_ctrl #(.DWELL_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .freq_start   (freq_start),
    .freq_stop    (freq_stop),
    .freq_step    (freq_step),
    .dwell        (dwell),
    .wave_sel_in  (wave_sel_in),
    .freq_word    (freq_word),
    .waveform_sel (waveform_sel),
    .busy         (busy),
    .done         (done),
    .sweep_cnt    (sweep_cnt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input int f, input int b, input int d, input int w);
    chk({tag, ".freq"}, 32'(freq_word), 32'(f));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".wave"}, 32'(waveform_sel), 32'(w));
  endtask

  task automatic scramble;
    freq_start  = 8'($urandom);
    freq_stop   = 8'($urandom);
    freq_step   = 8'($urandom);
    dwell       = DW'($urandom);
    wave_sel_in = 2'($urandom);
    loop_en     = 1'b0;
  endtask

  // One non-looped sweep, compared each cycle against the model frequency list.
  task automatic run_sweep(input int fs, input int fe, input int st, input int dw, input int w);
    int fl[$];
    int f;
    int s;
    int d;
    int wa;
    s = (st == 0) ? 1 : st;
    d = (dw == 0) ? 1 : dw;
    f = fs;
    fl.push_back(f);
    while (f != fe) begin
      if (fe >= fs) f = (f + s > fe) ? fe : f + s;
      else          f = (f - s < fe) ? fe : f - s;
      fl.push_back(f);
    end
`ifdef SWEEP_AUTO_WAVE_EN
    wa = (w + 1) % 4;
`else
    wa = w;
`endif
    freq_start  = 8'(fs);
    freq_stop   = 8'(fe);
    freq_step   = 8'(st);
    dwell       = DW'(dw);
    wave_sel_in = 2'(w);
    loop_en     = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    tick;
    chk_cycle("idle_follow", prev_f, 0, 0, w);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk_cycle("load", prev_f, 1, 0, w);
    tick;
    scramble;
    for (int i = 0; i < fl.size(); i++) begin
      for (int c = 0; c < d; c++) begin
        chk_cycle("dwell", fl[i], 1, 0, w);
        start = ($urandom_range(0, 7) == 0);
        tick;
      end
      if (i != fl.size() - 1) begin
        chk_cycle("step", fl[i], 1, 0, w);
        start = ($urandom_range(0, 7) == 0);
        tick;
      end
    end
    cnt_exp = (cnt_exp + 1) % 256;
    chk_cycle("done", fe, 1, 1, wa);
    chk("done.sweep_cnt", 32'(sweep_cnt), 32'(cnt_exp));
    tick;
    start = 1'b0;
    chk_cycle("after_done", fe, 0, 0, wa);
    chk("after_done.sweep_cnt", 32'(sweep_cnt), 32'(cnt_exp));
    prev_f = fe;
  endtask

  initial begin
    int w;
    int wl;
    total   = 0;
    bad     = 0;
    cnt_exp = 0;
    prev_f  = 0;
    rst_n   = 1'b1;
    start   = 1'b1;
    stop    = 1'b0;
    scramble;
    wave_sel_in = 2'd2;
    tick;
    tick;

    // Reset state, with start held high and a non-zero waveform input.
    chk_cycle("reset", 0, 0, 0, 0);
    chk("reset.sweep_cnt", 32'(sweep_cnt), 32'd0);
    rst_n = 1'b0;
    start = 1'b0;

    // Directed sweeps: up, down with clamp, saturation with zero step/dwell.
    run_sweep(10, 40, 10, 4, 1);
    run_sweep(200, 195, 8, 2, 2);
    run_sweep(250, 255, 0, 0, 3);
    run_sweep(7, 7, 3, 3, 0);
    run_sweep(5, 0, 200, 1, 1);

    // Abort during the third dwell of the up sweep.
    freq_start  = 8'd10;
    freq_stop   = 8'd40;
    freq_step   = 8'd10;
    dwell       = DW'(4);
    wave_sel_in = 2'd1;
    start       = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick;
    chk_cycle("abort_pre", 30, 1, 0, 1);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk_cycle("abort", 30, 0, 0, 1);
    chk("abort.sweep_cnt", 32'(sweep_cnt), 32'(cnt_exp));
    tick;
    chk_cycle("abort_idle", 30, 0, 0, 1);
    start = 1'b1;
    stop  = 1'b1;
    tick;
    chk_cycle("start_stop", 30, 0, 0, 1);
    tick;
    start = 1'b0;
    stop  = 1'b0;
    chk_cycle("start_stop2", 30, 0, 0, 1);
    prev_f = 30;

    // Random sweeps.
    for (int n = 0; n < 16; n++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
      run_sweep(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), st,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Looped single-point sweeps, then reset mid-sweep.
    freq_start  = 8'd5;
    freq_stop   = 8'd5;
    freq_step   = 8'd1;
    dwell       = DW'(2);
    loop_en     = 1'b1;
    wave_sel_in = 2'd3;
    start       = 1'b1;
    tick;
    start = 1'b0;
    chk_cycle("loop_load", prev_f, 1, 0, 3);
    w = 3;
    for (int sw = 0; sw < 3; sw++) begin
      tick;
      chk_cycle("loop_dwell0", 5, 1, 0, w);
      tick;
      chk_cycle("loop_dwell1", 5, 1, 0, w);
      tick;
      cnt_exp = (cnt_exp + 1) % 256;
`ifdef SWEEP_AUTO_WAVE_EN
      w = (w + 1) % 4;
`endif
      chk_cycle("loop_done", 5, 1, 1, w);
      chk("loop_done.sweep_cnt", 32'(sweep_cnt), 32'(cnt_exp));
      wl = int'($urandom_range(0, 3));
      wave_sel_in = 2'(wl);
      tick;
      chk_cycle("loop_reload", 5, 1, 0, w);
`ifndef SWEEP_AUTO_WAVE_EN
      w = wl;
`endif
    end
    tick;
    chk_cycle("loop_last", 5, 1, 0, w);
    rst_n = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    wave_sel_in = 2'd3;
    tick;
    chk_cycle("mid_reset", 0, 0, 0, 0);
    chk("mid_reset.sweep_cnt", 32'(sweep_cnt), 32'd0);
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    cnt_exp = 0;
    prev_f  = 0;
    tick;
    chk_cycle("post_reset", 0, 0, 0, 3);
    run_sweep(0, 3, 1, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_sweep_ctrl.md
WAVE_SWEEP_CTRL -- requirements
Module: wave_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: DWELL_W, default 16, width of the dwell counter and the dwell input.
REQ-003 Port: clk  input  1  system clock (10 MHz); all logic on rising edge.
REQ-004 Port: rst_n  input  1  synchronous reset, active-high despite the name.
REQ-005 Port: start  input  1  single-cycle request to begin a sweep.
REQ-006 Port: stop  input  1  single-cycle abort request.
REQ-007 Port: loop_en  input  1  1 = restart the sweep automatically after completion.
REQ-008 Port: freq_start  input  8  first frequency control word of the sweep.
REQ-009 Port: freq_stop  input  8  last frequency control word of the sweep.
REQ-010 Port: freq_step  input  8  step magnitude per dwell period.
REQ-011 Port: dwell  input  DWELL_W  clk cycles spent at each frequency.
REQ-012 Port: wave_sel_in  input  2  waveform selection used while the block is idle or the sweep starts.
REQ-013 Port: freq_word  output  8  frequency control word driven to the DDS generator.
REQ-014 Port: waveform_sel  output  2  waveform select driven to the DDS generator.
REQ-015 Port: busy  output  1  high in LOAD, DWELL, STEP and DONE.
REQ-016 Port: done  output  1  one-cycle pulse on sweep completion.
REQ-017 Port: sweep_cnt  output  8  completed-sweep counter; wraps 255->0.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, DWELL, STEP and DONE.
REQ-019 In IDLE, the block SHALL make waveform_sel follow wave_sel_in with one cycle of register latency.
REQ-020 In IDLE, the block SHALL hold freq_word at its last value.
REQ-021 In IDLE, when start=1 and stop=0, the block SHALL go to LOAD.
REQ-022 In LOAD (one cycle), the block SHALL latch freq_start, freq_stop, freq_step, dwell, loop_en and wave_sel_in.
REQ-023 Inputs changed after LOAD SHALL have no effect until the next LOAD.
REQ-024 In LOAD, the block SHALL set freq_word to freq_start, clear the dwell counter, and go to DWELL.
REQ-025 The block SHALL take direction from the latched values: up if freq_stop >= freq_start, otherwise down.
REQ-026 The block SHALL treat a latched freq_step of 0 as 1.
REQ-027 The block SHALL treat a latched dwell of 0 as 1.
REQ-028 In DWELL, the counter SHALL increment each cycle; when counter = dwell-1, the block SHALL go to STEP if freq_word != freq_stop, otherwise to DONE.
REQ-029 Each frequency SHALL therefore be held for exactly dwell cycles; STEP adds one cycle at the old value.
REQ-030 In STEP (one cycle), the block SHALL set freq_word to freq_word +/- step, computed 9 bits wide.
REQ-031 If that result passes freq_stop or leaves 0..255, the block SHALL clamp freq_word to freq_stop; it SHALL never wrap.
REQ-032 In STEP, the block SHALL clear the counter and go to DWELL.
REQ-033 In DONE (one cycle), the block SHALL assert done=1 and increment sweep_cnt.
REQ-034 From DONE, the block SHALL go to LOAD if latched loop_en=1, otherwise to IDLE.
REQ-035 A looped sweep SHALL re-latch all inputs in LOAD.
REQ-036 The last frequency SHALL be held until the next LOAD or indefinitely in IDLE.
REQ-037 If freq_start = freq_stop, the sweep SHALL consist of one dwell period then DONE.
REQ-038 stop=1 in any non-IDLE state SHALL force IDLE on the next edge, with freq_word held, no done pulse and sweep_cnt unchanged.
REQ-039 stop SHALL win over simultaneous start, and over a simultaneous DWELL->DONE transition.
REQ-040 start while busy SHALL be ignored.

Reset
REQ-041 On reset, state SHALL be IDLE, freq_word = 8'd0, waveform_sel = 2'b00, busy = 0, done = 0, sweep_cnt = 0, dwell counter = 0, and all latched registers = 0.
REQ-042 Reset SHALL override start and stop, and reset mid-sweep SHALL apply these values on the next edge.

Configuration
REQ-043 With SWEEP_AUTO_WAVE_EN defined, each DONE SHALL advance waveform_sel by 1 modulo 4 (3->0), taking effect the same cycle done is asserted.
REQ-044 With SWEEP_AUTO_WAVE_EN defined, a looped sweep SHALL keep the advanced value instead of re-latching wave_sel_in.
REQ-045 With SWEEP_AUTO_WAVE_EN undefined, waveform_sel SHALL equal the value latched in LOAD for the whole sweep.

Verification
REQ-046 Up sweep: start=10, stop=40, step=10, dwell=4, loop=0 -> freq_word 10,20,30,40, each held 4 cycles plus 1 STEP cycle (none after 40); done pulses once; sweep_cnt=1; IDLE.
REQ-047 Down sweep with clamp: start=200, stop=195, step=8, dwell=2 -> freq_word 200 then 195 (not 192); done once.
REQ-048 Saturation and zero inputs: start=250, stop=255, step=0, dwell=0 -> 250..255 in increments of 1, one cycle each plus STEP cycles; no wrap to 0.
REQ-049 Abort: stop pulsed during the third dwell of REQ-046 -> IDLE next cycle, freq_word=30, no done, busy=0; start and stop together -> remains IDLE.
REQ-050 Loop with SWEEP_AUTO_WAVE_EN: loop=1, start=stop=5, wave_sel_in=3 -> waveform_sel 3,0,1,... per done; sweep_cnt increments each sweep; reset mid-sweep -> all REQ-041 values on the next edge.
